product_accumulator: RTL
========================

# product_accumulator

Downstream stage for the 4x4 array multiplier. Consumes the 8-bit products over a valid/ready handshake and sums a programmable-length group of them. Each completed group sum is presented on a held valid/ready output. This lets the tile compute short dot products (sum of m×q pairs) without external logic.

## Interface
Parameters:
- ACC_W, default 12: accumulator and result width. Legal range 8..16. The default holds 16×225 = 3600 without overflow.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset. Deassertion is assumed synchronised externally.
- prod, input, 8: unsigned product from the multiplier (uo_out of the multiplier stage).
- in_valid, input, 1: prod is valid this cycle.
- in_ready, output, 1: block accepts prod this cycle. A product is accepted when in_valid && in_ready.
- len, input, 4: products per group. 0 means 16. Sampled only on the first accepted product of a group.
- out_sum, output, ACC_W: completed group sum.
- out_valid, output, 1: out_sum valid; held until accepted.
- out_ready, input, 1: consumer accepts out_sum when out_valid && out_ready.
- ovf, output, 1: sticky overflow flag. Cleared only by rst.

## Operation
- FSM, two states:
  - ACCUM (reset state).
  - HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - On accept with cnt==0: latch len into grp_len (0 → 16).
  - On a non-final accept: acc <= acc+prod and cnt <= cnt+1.
  - On the final accept (cnt == grp_len-1, including grp_len==1 on the first accept): out_sum <= acc+prod, acc <= 0, cnt <= 0, go to HOLD.
- HOLD:
  - in_ready=0, out_valid=1, out_sum stable.
  - On out_ready: go to ACCUM.
  - No product is accepted in the handshake cycle; the next group can start the following cycle.
- Arithmetic:
  - prod is zero-extended to ACC_W+1 bits before the add.
  - A carry out of bit ACC_W-1 is an overflow event and sets ovf.
  - Result handling on overflow depends on the Configuration macro.
- len changes mid-group are ignored. Only the value sampled on the first accept counts.
- in_valid while in HOLD: ignored; prod is not consumed. The upstream stage must keep it stable until accepted.
- Reset mid-group or mid-HOLD: the partial sum is discarded and the FSM returns to ACCUM immediately.
- Reset values: state=ACCUM, acc=0, cnt=0, grp_len=16, out_sum=0, out_valid=0, ovf=0, in_ready=0 while rst=1.

## Timing
- in_ready and out_valid are decoded from the registered state only. There is no combinational path from in_valid or out_ready to either.
- out_sum and ovf are registered.
- Latency: final product accepted at edge N → out_valid=1 and out_sum valid after edge N, i.e. in cycle N+1.
- Throughput: a group of L products takes L accept cycles, plus at least 1 HOLD cycle.
- Back-to-back maximum rate: L+1 cycles per group.
- Back-pressure: if out_ready stays low, HOLD persists indefinitely; out_sum and out_valid remain stable.
- ovf asserts in the cycle after the overflowing accept and stays asserted.

## Configuration
- PRODUCT_ACC_SATURATE_EN, defined: on overflow the running acc (or out_sum on the final accept) clamps to all-ones (2^ACC_W−1). Further adds in the same group stay clamped.
- Not defined: wrap modulo 2^ACC_W.
- ovf is set identically in both modes.

## Test plan
- Basic group: len=3; accept 225, 16, 1 on consecutive cycles → out_valid in the cycle after the third accept, out_sum=0x0F2, ovf=0. in_ready=0 until the out_ready handshake.
- Max group: len=0; 16 consecutive accepts of 225 → out_sum=0xE10 (3600), ovf=0. in_ready stays 1 for exactly 16 accepts.
- Overflow, ACC_W=8, len=2, products 200 then 100:
  - With PRODUCT_ACC_SATURATE_EN → out_sum=0xFF, ovf=1.
  - Without → out_sum=0x2C, ovf=1.
  - ovf stays 1 through the next non-overflowing group.
- Back-pressure and len change: len=1 with prod=7 → HOLD. Hold out_ready=0 for 5 cycles while driving in_valid=1 and len=5:
  - out_sum=7 stable, in_ready=0, nothing consumed.
  - After out_ready=1, the next group uses len=5.
- Reset mid-group: len=4; accept 50, 60. Assert rst asynchronously between edges → out_valid=0, in_ready=0 immediately. After release, len=1 with prod=9 → out_sum=9, not 119.
- Valid gaps: len=3; products 10, 20, 30 with in_valid low for 2 cycles between each → out_sum=60. Gaps neither advance cnt nor modify acc.

Source files
------------

// File: rtl/product_accumulator.sv
// Sums programmable-length groups of 8-bit products and presents each group sum on a held valid/ready output.
// Optional feature: define PRODUCT_ACC_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       len,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [4:0]       grp_len_q, grp_len_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             first;
  logic             last;
  logic [4:0]       eff_len;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] res;

  // Handshake outputs depend only on registered state (and reset), never on in_valid/out_ready.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign ovf       = ovf_q;

  assign accept  = in_valid && in_ready;
  assign first   = (cnt_q == 4'd0);
  assign eff_len = first ? ((len == 4'd0) ? 5'd16 : {1'b0, len}) : grp_len_q;
  assign last    = ({1'b0, cnt_q} == (eff_len - 5'd1));

  assign sum   = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};
  assign carry = sum[ACC_W];

`ifdef PRODUCT_ACC_SATURATE_EN
  // A clamped acc re-overflows on any nonzero add, so it stays pinned for the rest of the group.
  assign res = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign res = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    grp_len_d = grp_len_q;
    out_sum_d = out_sum_q;
    ovf_d     = ovf_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (first) grp_len_d = eff_len;
          if (carry) ovf_d = 1'b1;
          if (last) begin
            out_sum_d = res;
            acc_d     = '0;
            cnt_d     = 4'd0;
            state_d   = HOLD;
          end else begin
            acc_d = res;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= 4'd0;
      grp_len_q <= 5'd16;
      out_sum_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      grp_len_q <= grp_len_d;
      out_sum_q <= out_sum_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
